serial_digit_adder: RTL and testbench

Multi-cycle, parametrised add/subtract unit that processes WIDTH-bit operands DIGIT bits per clock through a registered carry. It trades the single-cycle full-width ripple path for a short DIGIT-bit critical path. It sits between a simple datapath controller and the register file, using a start/busy/done handshake. It extends the single-bit full-adder primitive with width, digit-serial sequencing, a subtract mode and signed-overflow detection.

---
 rtl/serial_digit_adder_pkg.sv | 18 +
 rtl/serial_digit_adder_digit_adder.sv | 28 ++
 rtl/serial_digit_adder.sv | 137 +++++++++++++
 tb/tb_serial_digit_adder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_digit_adder_pkg.sv
// Shared state encoding, default geometry and step-count helper for the digit-serial adder.
package serial_digit_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned DIGIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of digit steps needed to cover a full operand.
    function automatic int unsigned num_steps(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice; c_msb is the carry into the top bit for overflow.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    always_comb begin
        logic carry;
        carry = ci;
        s     = '0;
        c_msb = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) begin
                c_msb = carry;
            end
            s[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract unit: WIDTH-bit operands consumed DIGIT bits per cycle
// through a registered carry, with a start/busy/done handshake.
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DIGIT = DIGIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N     = num_steps(WIDTH, DIGIT);
    localparam int unsigned CNT_W = $clog2(N) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_s_c;
    logic             dig_co_c;
    logic             dig_cmsb_c;
    logic [WIDTH-1:0] acc_step_c;
    logic             last_step_c;
    logic             accept_c;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .x     (a_sh_q[DIGIT-1:0]),
        .y     (b_sh_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s_c),
        .co    (dig_co_c),
        .c_msb (dig_cmsb_c)
    );

    // New digit enters at the top so the LSB digit ends up at bit 0 after N steps.
    assign acc_step_c  = (acc_q >> DIGIT) | (WIDTH'(dig_s_c) << (WIDTH - DIGIT));
    assign last_step_c = (cnt_q == CNT_W'(N - 1));
    assign accept_c    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                acc_d   = acc_step_c;
                carry_d = dig_co_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_step_c) begin
                    state_d = ST_DONE;
                    sum_d   = acc_step_c;
                    cout_d  = dig_co_c;
                    ovf_d   = dig_co_c ^ dig_cmsb_c;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Subtraction is a + ~b + 1: invert B on load and force the initial carry.
        if (accept_c) begin
            state_d = ST_RUN;
            a_sh_d  = a;
            b_sh_d  = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            cnt_d   = '0;
            acc_d   = '0;
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: transaction model checked every cycle plus directed literal vectors.
module tb_serial_digit_adder;

    localparam int unsigned W = 16;
    localparam int unsigned D = 4;
    localparam int unsigned N = W / D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sub, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, overflow;
    logic [15:0] sum;

    logic        start8, sub8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;

    serial_digit_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    serial_digit_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: plain integer math on the operands.
    function automatic void ref_op(input logic [15:0] x, input logic [15:0] y, input bit ci,
                                   input bit s, output logic [15:0] r, output bit co, output bit ov);
        int sx, sy, sr;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            r  = x - y;
            co = (x >= y);
            sr = sx - sy;
        end else begin
            r  = x + y + 16'(ci);
            co = (32'(x) + 32'(y) + 32'(ci)) > 32'd65535;
            sr = sx + sy + int'(ci);
        end
        ov = (sr > 32767) || (sr < -32768);
    endfunction

    // Transaction-level model: cycles left until result, held result values.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [15:0] h_sum = '0, p_sum = '0;
    bit          h_cout = 1'b0, p_cout = 1'b0, h_ovf = 1'b0, p_ovf = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin : model
        bit acc;
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            h_sum  = '0;
            h_cout = 1'b0;
            h_ovf  = 1'b0;
        end else begin
            acc    = (m_left == 0) && start;
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    h_sum  = p_sum;
                    h_cout = p_cout;
                    h_ovf  = p_ovf;
                end
            end
            if (acc) begin
                m_left = int'(N);
                ref_op(a, b, cin, sub, p_sum, p_cout, p_ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc busy", 32'(busy), 32'(m_left > 0));
            chk("cyc done", 32'(done), 32'(m_done));
            chk("cyc sum", 32'(sum), 32'(h_sum));
            chk("cyc cout", 32'(cout), 32'(h_cout));
            chk("cyc overflow", 32'(overflow), 32'(h_ovf));
        end
    end

    task automatic do_op(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input bit ci, input bit s, input logic [15:0] es, input bit ec, input bit eo);
        int lat;
        lat = 0;
        a = x; b = y; cin = ci; sub = s; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'(N + 1));
        chk({nm, " sum"}, 32'(sum), 32'(es));
        chk({nm, " cout"}, 32'(cout), 32'(ec));
        chk({nm, " overflow"}, 32'(overflow), 32'(eo));
    endtask

    task automatic do_op8(input string nm, input logic [7:0] x, input logic [7:0] y, input bit s,
                          input logic [7:0] es, input bit ec, input bit eo);
        int lat;
        lat = 0;
        a8 = x; b8 = y; cin8 = 1'b0; sub8 = s; start8 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'd2);
        chk({nm, " sum"}, 32'(sum8), 32'(es));
        chk({nm, " cout"}, 32'(cout8), 32'(ec));
        chk({nm, " overflow"}, 32'(ovf8), 32'(eo));
        chk({nm, " busy after"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset sum8", 32'(sum8), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk); #1;
        do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        @(posedge clk); #1;
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        @(posedge clk); #1;
        do_op("sub_cin_ignored", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        @(posedge clk); #1;
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Second start while busy must be dropped.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (dones == 1) chk("ignored_start sum", 32'(sum), 32'h2345);
            end
        end
        chk("ignored_start done pulses", 32'(dones), 32'd1);

        // Back-to-back: second start raised in the done cycle of the first.
        do_op("b2b_first", 16'h00F0, 16'h000F, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0);
        do_op("b2b_second", 16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0);

        // Reset during the second digit step.
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum", 32'(sum), 32'd0);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort no done", 32'(dones), 32'd0);
        do_op("after_reset", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

        @(posedge clk); #1;
        do_op8("w8_add", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        @(posedge clk); #1;
        do_op8("w8_sub", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
